md_sequencer: RTL and testbench

//  Sequences the E-stage multiply/divide unit and owns the HI/LO registers.

---
 rtl/md_sequencer.sv | 145 ++++++++++++++
 tb/tb_md_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, runs a fixed-latency
// busy window per mult/div command and raises the D-stage stall request.
module md_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic [1:0]  hilo_sel,
    input  logic        md_instr_d,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;

    logic        accept, is_mul, is_div, commit;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    // Arithmetic datapath, evaluated on the operands present at the accept edge.
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, dvs_s, dvs_u, q_s_mag, r_s_mag, q_u, r_u;
    logic        neg_a, neg_b;

    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide done on magnitudes; 0x80000000/-1 falls out as
    // quotient 0x80000000, remainder 0 with no special case.
    assign neg_a   = rs_val[31];
    assign neg_b   = rt_val[31];
    assign abs_a   = neg_a ? (~rs_val + 32'd1) : rs_val;
    assign abs_b   = neg_b ? (~rt_val + 32'd1) : rt_val;
    assign dvs_s   = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign dvs_u   = (rt_val == 32'd0) ? 32'd1 : rt_val;
    assign q_s_mag = abs_a / dvs_s;
    assign r_s_mag = abs_a % dvs_s;
    assign q_u     = rs_val / dvs_u;
    assign r_u     = rs_val % dvs_u;

    assign accept = start && !flush && (state == IDLE);
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign commit = (state == RUN) && (cnt == '0);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_lo = (neg_a ^ neg_b) ? (~q_s_mag + 32'd1) : q_s_mag;
                res_hi = neg_a ? (~r_s_mag + 32'd1) : r_s_mag;
                res_wr = (rt_val != 32'd0);
            end
            OP_DIVU: begin
                res_lo = q_u;
                res_hi = r_u;
                res_wr = (rt_val != 32'd0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && (is_mul || is_div)) state_nx = RUN;
            RUN:  if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state <= state_nx;
            done  <= commit;
            if (accept && (is_mul || is_div)) begin
                busy    <= 1'b1;
                cnt     <= is_mul ? CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
            end else if (commit) begin
                busy <= 1'b0;
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end
            if (accept && (op == OP_MTHI)) hi <= rs_val;
            if (accept && (op == OP_MTLO)) lo <= rs_val;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (hilo_sel)
            2'b01:   rd_data = hi;
            2'b10:   rd_data = lo;
            default: rd_data = 32'd0;
        endcase
    end

    assign md_stall = (start || busy) && md_instr_d;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: hand-computed HI/LO results, busy length,
// done pulse, stall, flush and reset boundary cases.
module tb_md_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        flush;
    logic [1:0]  hilo_sel;
    logic        md_instr_d;
    logic        busy, done, md_stall;
    logic [31:0] rd_data, hi, lo;

    int checks = 0;
    int errors = 0;

    md_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .flush(flush), .hilo_sel(hilo_sel),
        .md_instr_d(md_instr_d), .busy(busy), .done(done), .rd_data(rd_data),
        .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div command, count busy cycles, then check commit.
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int flush_at);
        int n;
        start = 1'b1; op = o; rs_val = a; rt_val = b; md_instr_d = 1'b1;
        #1;
        chk({tag, " stall_at_start"}, {31'd0, md_stall}, 32'd1);
        tick();
        start = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'h0;
        n = 0;
        while (busy && n < 50) begin
            chk({tag, " stall_busy"}, {31'd0, md_stall}, 32'd1);
            chk({tag, " no_done"}, {31'd0, done}, 32'd0);
            n++;
            flush = (n == flush_at);
            tick();
        end
        flush = 1'b0;
        chk({tag, " busy_cycles"}, n, exp_n);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " stall_clear"}, {31'd0, md_stall}, 32'd0);
        md_instr_d = 1'b0;
        tick();
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'b000; rs_val = 32'd0; rt_val = 32'd0;
        flush = 1'b0; hilo_sel = 2'b00; md_instr_d = 1'b0;
        tick(); tick();
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        run_md("mult", 3'b000, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        run_md("divu", 3'b011, 32'd100, 32'd7, 10, 32'd2, 32'd14, 0);
        run_md("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_md("div0", 3'b010, 32'd55, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

        // mthi / mtlo: immediate write, no busy
        start = 1'b1; op = 3'b100; rs_val = 32'h0000_1234;
        tick();
        start = 1'b0;
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("mthi hi", hi, 32'h0000_1234);
        chk("mthi lo", lo, 32'hFFFF_FFFD);
        hilo_sel = 2'b01; #1;
        chk("rd hi", rd_data, 32'h0000_1234);
        hilo_sel = 2'b10; #1;
        chk("rd lo", rd_data, 32'hFFFF_FFFD);
        hilo_sel = 2'b11; #1;
        chk("rd none", rd_data, 32'd0);
        hilo_sel = 2'b00;
        start = 1'b1; op = 3'b101; rs_val = 32'h0000_ABCD;
        tick();
        start = 1'b0;
        chk("mtlo lo", lo, 32'h0000_ABCD);
        chk("mtlo hi", hi, 32'h0000_1234);
        tick();
        chk("mt no_done", {31'd0, done}, 32'd0);

        // start + flush same cycle is suppressed
        start = 1'b1; flush = 1'b1; op = 3'b000; rs_val = 32'd3; rt_val = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start busy", {31'd0, busy}, 32'd0);
        tick();
        chk("flush_start hi", hi, 32'h0000_1234);
        chk("flush_start lo", lo, 32'h0000_ABCD);

        // undefined op is a no-op
        start = 1'b1; op = 3'b110; rs_val = 32'h5555_5555;
        tick();
        start = 1'b0;
        chk("undef busy", {31'd0, busy}, 32'd0);
        chk("undef hi", hi, 32'h0000_1234);
        chk("undef lo", lo, 32'h0000_ABCD);

        run_md("mult_flush", 3'b000, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0, 2);
        run_md("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 0);
        run_md("multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 0);

        // reset in the middle of a running mult
        start = 1'b1; op = 3'b000; rs_val = 32'd7; rt_val = 32'd9;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("rstmid busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        chk("rstmid busy", {31'd0, busy}, 32'd0);
        chk("rstmid hi", hi, 32'd0);
        chk("rstmid lo", lo, 32'd0);
        chk("rstmid done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstmid no_done", {31'd0, done}, 32'd0);
        end
        chk("rstmid lo_after", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
